// File: rtl/ram_mp_banked_if.sv
// Request/response bundle between the cores and the banked data memory.
// Handshake: a transaction commits at the rising edge where req & gnt; a losing port holds req/we/addr/wdata/be stable until granted.
interface ram_mp_banked_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_PORTS-1:0]              req;
  logic [NUM_PORTS-1:0]              we;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be;
  logic [NUM_PORTS-1:0]              gnt;
  logic [NUM_PORTS-1:0]              rvalid;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_mp_banked.sv
// Multi-port, bank-interleaved synchronous RAM with per-bank round-robin arbitration.
// Bank = low address bits; reads return registered data one cycle after grant.
module ram_mp_banked #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 12,
  parameter int NUM_BANKS    = 4,
  parameter int INIT_PATTERN = 1
) (
  input  logic             clk,
  input  logic             reset,
  ram_mp_banked_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_PATTERN != 0) ? DATA_WIDTH'(i) : '0;
    end
    return m;
  endfunction

  // Contents are deliberately outside the reset domain so they survive reset.
  mem_t mem_q = init_mem();

  logic [ADDR_WIDTH-1:0] addr_w  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_w [NUM_PORTS];
  logic [NB-1:0]         be_w    [NUM_PORTS];
  logic [BW-1:0]         bank_w  [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_w[p]  = bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_w[p] = bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
      be_w[p]    = bus.be[p*NB +: NB];
      bank_w[p]  = (NUM_BANKS > 1) ? addr_w[p][BW-1:0] : '0;
    end
  end

  logic [PW-1:0]          ptr_q [NUM_BANKS];
  logic [PW-1:0]          ptr_d [NUM_BANKS];
  logic [PW-1:0]          win   [NUM_BANKS];
  logic [NUM_BANKS-1:0]   found;
  logic [PW-1:0]          idx;
  logic [NUM_PORTS-1:0]   gnt;

  // Per bank: first requester at or after the pointer, searching upward mod NUM_PORTS.
  always_comb begin
    gnt   = '0;
    found = '0;
    idx   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win[b]   = '0;
      ptr_d[b] = ptr_q[b];
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = PW'((int'(ptr_q[b]) + k) % NUM_PORTS);
        if (!found[b] && bus.req[idx] && (int'(bank_w[idx]) == b)) begin
          found[b] = 1'b1;
          win[b]   = idx;
        end
      end
      if (found[b] && !reset) begin
        gnt[win[b]] = 1'b1;
        ptr_d[b]    = (int'(win[b]) == NUM_PORTS - 1) ? '0 : win[b] + 1'b1;
      end
    end
  end

  assign bus.gnt = gnt;

  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rdata_q[p] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
      for (int p = 0; p < NUM_PORTS; p++) begin
        rvalid_q[p] <= gnt[p] & ~bus.we[p];
        if (gnt[p] && !bus.we[p]) rdata_q[p] <= mem_q[addr_w[p]];
      end
    end
  end

  // gnt is forced low during reset, so no write can land while reset is high.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p] && bus.we[p]) begin
        for (int j = 0; j < NB; j++) begin
          if (be_w[p][j]) mem_q[addr_w[p]][j*8 +: 8] <= wdata_w[p][j*8 +: 8];
        end
      end
    end
  end

  assign bus.rvalid = rvalid_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    end
  end
endmodule

// File: tb/tb_ram_mp_banked.sv
// Directed bench for ram_mp_banked: driver pushes expected grants/read data, a negedge monitor checks them.
module tb_ram_mp_banked;
  localparam int NP = 4;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int NB = DW / 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_mp_banked_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_mp_banked #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(4), .INIT_PATTERN(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [NP][$];
  logic [7:0]    item_q [$];
  logic [3:0]    prev_rv = '0;
  logic [DW-1:0] wd  [NP];
  logic [NB-1:0] bes [NP];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One cycle of stimulus, called just after a rising edge; eg = expected grants this cycle.
  task automatic drive(input logic [3:0] r, input logic [3:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                       input logic [3:0] eg,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    logic [AW-1:0] a [NP];
    logic [DW-1:0] e [NP];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    bus.req = r;
    bus.we  = w;
    for (int p = 0; p < NP; p++) begin
      bus.addr[p*AW +: AW]  = a[p];
      bus.wdata[p*DW +: DW] = wd[p];
      bus.be[p*NB +: NB]    = bes[p];
    end
    item_q.push_back({eg & ~w, eg});
    for (int p = 0; p < NP; p++) begin
      if (eg[p] && !w[p]) exp_q[p].push_back(e[p]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
  endtask

  // Monitor: gnt against this cycle's expectation, rvalid/rdata against the previous cycle's reads.
  always @(negedge clk) begin
    logic [7:0]    it;
    logic [DW-1:0] ev;
    if (item_q.size() > 0) begin
      it = item_q.pop_front();
      check("gnt", DW'(bus.gnt), DW'(it[3:0]));
      check("rvalid", DW'(bus.rvalid), DW'(prev_rv));
      for (int p = 0; p < NP; p++) begin
        if (prev_rv[p] && bus.rvalid[p] && exp_q[p].size() > 0) begin
          ev = exp_q[p].pop_front();
          check($sformatf("rdata%0d", p), bus.rdata[p*DW +: DW], ev);
        end
      end
      prev_rv = it[7:4];
    end
  end

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    for (int p = 0; p < NP; p++) begin
      wd[p]  = '0;
      bes[p] = '0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    drive(4'b1111, 4'b0000, 0, 1, 2, 3, 4'b0000, 0, 0, 0, 0);
    drive(4'b1111, 4'b0000, 0, 1, 2, 3, 4'b0000, 0, 0, 0, 0);
    for (int p = 0; p < NP; p++)
      check($sformatf("reset_rdata%0d", p), bus.rdata[p*DW +: DW], '0);
    reset = 1'b0;

    // Single read of init pattern word 5.
    drive(4'b0001, 4'b0000, 5, 0, 0, 0, 4'b0001, 5, 0, 0, 0);
    idle();
    idle();

    // All ports on bank 0: round robin from port 0, twice.
    for (int rep = 0; rep < 2; rep++) begin
      drive(4'b1111, 4'b0000, 0, 4, 8, 12, 4'b0001, 0, 4, 8, 12);
      drive(4'b1110, 4'b0000, 0, 4, 8, 12, 4'b0010, 0, 4, 8, 12);
      drive(4'b1100, 4'b0000, 0, 4, 8, 12, 4'b0100, 0, 4, 8, 12);
      drive(4'b1000, 4'b0000, 0, 4, 8, 12, 4'b1000, 0, 4, 8, 12);
    end
    idle();

    // Four distinct banks in parallel.
    drive(4'b1111, 4'b0000, 0, 1, 2, 3, 4'b1111, 0, 1, 2, 3);
    idle();

    // Byte-masked write then read-back from another port.
    wd[1]  = 128'h1234;
    bes[1] = 16'h0001;
    drive(4'b0010, 4'b0010, 0, 12'h107, 0, 0, 4'b0010, 0, 0, 0, 0);
    drive(4'b0100, 4'b0000, 0, 0, 12'h107, 0, 4'b0100, 0, 0, 128'h134, 0);
    idle();

    // Port 3 alone on bank 1 wraps the pointer to 0, then ports 0 and 3 alternate.
    drive(4'b1000, 4'b0000, 0, 0, 0, 9, 4'b1000, 0, 0, 0, 9);
    for (int rep = 0; rep < 2; rep++) begin
      drive(4'b1001, 4'b0000, 1, 0, 0, 5, 4'b0001, 1, 0, 0, 5);
      drive(4'b1001, 4'b0000, 1, 0, 0, 5, 4'b1000, 1, 0, 0, 5);
    end
    idle();

    // Write before reset, then a granted read killed by reset before its edge.
    wd[0]  = 128'hAABB;
    bes[0] = 16'h0003;
    drive(4'b0001, 4'b0001, 12'h20, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    bus.req = 4'b0001;
    bus.we  = 4'b0000;
    bus.addr[0 +: AW] = 12'h10;
    item_q.push_back(8'b0000_0001);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_kill_rdata0", bus.rdata[0 +: DW], '0);
    check("reset_kill_rvalid", DW'(bus.rvalid), '0);
    check("reset_kill_gnt", DW'(bus.gnt), '0);
    @(posedge clk);
    #1;
    drive(4'b0001, 4'b0000, 12'h10, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    reset = 1'b0;

    // Pointers back at 0 and the pre-reset write retained.
    drive(4'b1111, 4'b0000, 12'h20, 4, 8, 12, 4'b0001, 128'hAABB, 4, 8, 12);
    drive(4'b1110, 4'b0000, 12'h20, 4, 8, 12, 4'b0010, 128'hAABB, 4, 8, 12);
    drive(4'b1100, 4'b0000, 12'h20, 4, 8, 12, 4'b0100, 128'hAABB, 4, 8, 12);
    drive(4'b1000, 4'b0000, 12'h20, 4, 8, 12, 4'b1000, 128'hAABB, 4, 8, 12);
    idle();
    idle();
    @(negedge clk);

    for (int p = 0; p < NP; p++)
      check($sformatf("pending_reads%0d", p), DW'(exp_q[p].size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
